// File: rtl/dig_bcd_bridge_if.sv
// CPU-side register bus for the BCD display bridge: byte address, write strobe,
// write data and combinational read data.
interface dig_bcd_bridge_if;
  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output wen, output wdata, input rdata);
  modport slave  (input addr, input wen, input wdata, output rdata);
endinterface

// File: rtl/dig_bcd_bridge.sv
// Memory-mapped bridge to an 8-digit display: RAW words pass straight through,
// BIN words are clamped to 99_999_999 and converted to BCD by serial double-dabble.
module dig_bcd_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_F000
) (
  input  logic                   clk,
  input  logic                   rst,
  dig_bcd_bridge_if.slave        bus,
  output logic                   out_wen,
  output logic [31:0]            out_wdata,
  output logic                   busy
);

  typedef enum logic {IDLE, CONV} state_t;

  localparam logic [31:0] RAW_ADDR  = BASE_ADDR;
  localparam logic [31:0] BIN_ADDR  = BASE_ADDR + 32'd4;
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd8;
  localparam logic [31:0] BIN_MAX   = 32'd99_999_999;
  localparam logic [4:0]  LAST_ITER = 5'd26;

  state_t      state, state_nx;
  logic [31:0] bin_reg;
  logic [31:0] bcd_reg, bcd_adj, bcd_nx;
  logic [26:0] sh_reg, sh_nx;
  logic [4:0]  iter;
  logic        wr_raw, wr_bin, last_step;
  logic [31:0] clamped;

  assign wr_raw    = bus.wen && (bus.addr == RAW_ADDR);
  assign wr_bin    = bus.wen && (bus.addr == BIN_ADDR);
  assign clamped   = (bus.wdata > BIN_MAX) ? BIN_MAX : bus.wdata;
  assign busy      = (state == CONV);
  assign last_step = (state == CONV) && (iter == LAST_ITER);

  // One double-dabble step: add-3 correction per nibble, then shift {bcd, bin}.
  always_comb begin
    bcd_adj = bcd_reg;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bcd_reg[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
    end
    {bcd_nx, sh_nx} = {bcd_adj[30:0], sh_reg, 1'b0};
  end

  always_comb begin
    state_nx = state;
    if (wr_raw)
      state_nx = IDLE;
    else if (wr_bin)
      state_nx = CONV;
    else if (last_step)
      state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // A RAW write outranks an in-flight conversion, which is simply dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_wen   <= 1'b0;
      out_wdata <= '0;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      sh_reg    <= '0;
      iter      <= '0;
    end else begin
      out_wen <= 1'b0;
      if (wr_raw) begin
        out_wdata <= bus.wdata;
        out_wen   <= 1'b1;
      end else if (wr_bin) begin
        bin_reg <= clamped;
        sh_reg  <= clamped[26:0];
        bcd_reg <= '0;
        iter    <= '0;
      end else if (state == CONV) begin
        bcd_reg <= bcd_nx;
        sh_reg  <= sh_nx;
        if (iter == LAST_ITER) begin
          out_wdata <= bcd_nx;
          out_wen   <= 1'b1;
        end else begin
          iter <= iter + 5'd1;
        end
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.addr == RAW_ADDR)
      bus.rdata = out_wdata;
    else if (bus.addr == BIN_ADDR)
      bus.rdata = bin_reg;
    else if (bus.addr == STAT_ADDR)
      bus.rdata = {31'b0, busy};
  end

endmodule

// File: tb/tb_dig_bcd_bridge.sv
// Directed bench for dig_bcd_bridge: inputs change on the falling edge,
// outputs are sampled on the falling edge or just after an address change.
module tb_dig_bcd_bridge;

  localparam logic [31:0] BASE = 32'hFFFF_F000;
  localparam logic [31:0] RAW  = BASE;
  localparam logic [31:0] BIN  = BASE + 32'd4;
  localparam logic [31:0] STAT = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_wen;
  logic [31:0] out_wdata;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned pulses = 0;

  dig_bcd_bridge_if bus ();

  dig_bcd_bridge #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .out_wen   (out_wen),
    .out_wdata (out_wdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_wen === 1'b1) pulses++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge just after the accept edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.wen   = 1'b1;
    @(negedge clk);
    bus.wen   = 1'b0;
    bus.addr  = '0;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check_eq(tag, bus.rdata, exp);
    bus.addr = '0;
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  // Counts falling edges with busy high, bounded so a stuck FSM cannot hang the run.
  task automatic wait_done(input string tag, input logic [31:0] exp_val);
    int unsigned n;
    int unsigned p0;
    n  = 0;
    p0 = pulses;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_busy_cycles"}, n, 32'd27);
    check_eq({tag, "_wen_at_done"}, {31'b0, out_wen}, 32'd1);
    check_eq({tag, "_value"}, out_wdata, exp_val);
    @(negedge clk);
    check_eq({tag, "_wen_one_cycle"}, {31'b0, out_wen}, 32'd0);
    check_eq({tag, "_pulse_count"}, pulses - p0, 32'd1);
  endtask

  initial begin
    int unsigned p0;
    bus.addr  = '0;
    bus.wen   = 1'b0;
    bus.wdata = '0;
    rst       = 1'b1;
    idle_cycles(2);
    check_eq("rst_out_wen", {31'b0, out_wen}, 32'd0);
    check_eq("rst_out_wdata", out_wdata, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    bus_read("rst_rd_bin", BIN, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Plain conversion, first write after reset
    bus_write(BIN, 32'd12_345_678);
    check_eq("conv_busy_e0", {31'b0, busy}, 32'd1);
    bus_read("conv_rd_stat", STAT, 32'd1);
    wait_done("conv1", 32'h1234_5678);
    bus_read("conv_rd_raw", RAW, 32'h1234_5678);
    bus_read("conv_rd_bin", BIN, 32'd12_345_678);

    // Zero and clamping boundaries
    bus_write(BIN, 32'd0);
    wait_done("zero", 32'h0000_0000);
    bus_write(BIN, 32'hFFFF_FFFF);
    bus_read("clamp_rd_bin", BIN, 32'd99_999_999);
    wait_done("clamp", 32'h9999_9999);
    bus_write(BIN, 32'd100_000_000);
    bus_read("clamp_edge_rd_bin", BIN, 32'd99_999_999);
    wait_done("clamp_edge", 32'h9999_9999);
    bus_write(BIN, 32'd99_999_998);
    bus_read("max_minus1_rd_bin", BIN, 32'd99_999_998);
    wait_done("max_minus1", 32'h9999_9998);

    // RAW pass-through
    p0 = pulses;
    bus_write(RAW, 32'hDEAD_BEEF);
    check_eq("raw_wen", {31'b0, out_wen}, 32'd1);
    check_eq("raw_value", out_wdata, 32'hDEAD_BEEF);
    check_eq("raw_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check_eq("raw_wen_drop", {31'b0, out_wen}, 32'd0);
    idle_cycles(5);
    check_eq("raw_pulse_count", pulses - p0, 32'd1);

    // STAT and unmapped writes have no effect
    p0 = pulses;
    bus_write(STAT, 32'hFFFF_FFFF);
    bus_write(BASE + 32'd12, 32'h1111_1111);
    bus_write(BASE - 32'd4, 32'h2222_2222);
    check_eq("nop_busy", {31'b0, busy}, 32'd0);
    check_eq("nop_value", out_wdata, 32'hDEAD_BEEF);
    check_eq("nop_pulse_count", pulses - p0, 32'd0);
    bus_read("unmapped_rd", BASE + 32'd12, 32'd0);

    // BIN restart mid-conversion, with a STAT write in between
    p0 = pulses;
    bus_write(BIN, 32'd1111);
    idle_cycles(3);
    bus_write(STAT, 32'd0);
    idle_cycles(5);
    bus_write(BIN, 32'd2222);
    check_eq("restart_no_early", pulses - p0, 32'd0);
    wait_done("restart", 32'h0000_2222);

    // RAW aborts a conversion
    p0 = pulses;
    bus_write(BIN, 32'd5);
    idle_cycles(4);
    bus_write(RAW, 32'h0000_ABCD);
    check_eq("abort_wen", {31'b0, out_wen}, 32'd1);
    check_eq("abort_value", out_wdata, 32'h0000_ABCD);
    check_eq("abort_busy", {31'b0, busy}, 32'd0);
    idle_cycles(40);
    check_eq("abort_pulse_count", pulses - p0, 32'd1);
    check_eq("abort_value_held", out_wdata, 32'h0000_ABCD);

    // Reset mid-conversion, with a write attempted while reset is held
    p0 = pulses;
    bus_write(BIN, 32'd87_654_321);
    idle_cycles(14);
    rst = 1'b1;
    #1;
    check_eq("rst_async_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_async_value", out_wdata, 32'd0);
    @(negedge clk);
    bus_write(RAW, 32'h5555_5555);
    rst = 1'b0;
    idle_cycles(40);
    check_eq("rst_mid_pulse_count", pulses - p0, 32'd0);
    check_eq("rst_mid_value", out_wdata, 32'd0);
    check_eq("rst_mid_busy", {31'b0, busy}, 32'd0);
    bus_read("rst_mid_rd_stat", STAT, 32'd0);
    bus_read("rst_mid_rd_bin", BIN, 32'd0);

    // No added latency after reset
    @(negedge clk);
    bus_write(BIN, 32'd907);
    wait_done("post_rst", 32'h0000_0907);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dig_bcd_bridge.md
DIG_BCD_BRIDGE -- requirements
Module: dig_bcd_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hFFFF_F000, byte address of register block.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port addr  input  32  CPU bus byte address.
REQ-005 SHALL have port wen  input  1  CPU write strobe, one access per cycle.
REQ-006 SHALL have port wdata  input  32  CPU write data.
REQ-007 SHALL have port rdata  output  32  combinational read data for addr.
REQ-008 SHALL have port out_wen  output  1  registered one-cycle write strobe to the 8-digit display driver.
REQ-009 SHALL have port out_wdata  output  32  registered display word, 8 hex nibbles, [31:28] leftmost digit.
REQ-010 SHALL have port busy  output  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-011 SHALL decode RAW = BASE_ADDR+0, BIN = BASE_ADDR+4, STAT = BASE_ADDR+8; all other addresses ignored on write, read as 0.
REQ-012 SHALL accept a write on a rising edge where wen=1 and addr matches RAW or BIN (accept edge E0).
REQ-013 RAW write: at E0 out_wdata <= wdata, out_wen <= 1; out_wen high exactly the one cycle E0..E1.
REQ-014 BIN write: at E0 value = (wdata > 99_999_999 unsigned) ? 99_999_999 : wdata; store in bin_reg; load 27-bit conversion register; iteration count <= 0; state IDLE -> CONV.
REQ-015 FSM states IDLE, CONV only; busy = (state == CONV), registered state, no combinational dependence on wen.
REQ-016 CONV: on each edge E1..E27, one double-dabble iteration: every BCD nibble >= 5 gets +3, then the {bcd[31:0], bin[26:0]} concatenation shifts left 1.
REQ-017 At E27: out_wdata <= final 8-digit BCD, out_wen <= 1 for one cycle, state <= IDLE; busy low from E27.
REQ-018 out_wen SHALL be 0 in every cycle not specified by REQ-013/REQ-017; out_wdata SHALL hold its last value otherwise.
REQ-019 BIN write during CONV: current conversion aborted without out_wen; restart per REQ-014 with new value.
REQ-020 RAW write during CONV: conversion aborted, no BCD result emitted; RAW handled per REQ-013; state <= IDLE.
REQ-021 Write to STAT or unmapped address SHALL have no effect, including during CONV.
REQ-022 rdata: RAW -> out_wdata; BIN -> bin_reg (clamped value); STAT -> {31'b0, busy}; else 0.
REQ-023 Iteration counter 5 bits, counts 0..26; no wrap beyond 27 iterations.

Reset
REQ-024 rst=1 SHALL asynchronously force state IDLE, busy 0, out_wen 0, out_wdata 0, bin_reg 0, counter 0, conversion register 0.
REQ-025 rst asserted mid-conversion SHALL abort without out_wen pulse; writes during rst ignored.
REQ-026 After rst deasserts, first accepted write behaves per REQ-013/014 with no extra latency.

Verification
REQ-027 Reset, write BIN=12_345_678 -> busy high 27 cycles, out_wen single pulse after E27, out_wdata=0x12345678, rdata@RAW=0x12345678.
REQ-028 Write BIN=0 -> out_wdata=0x00000000 after E27; write BIN=0xFFFFFFFF -> rdata@BIN=99_999_999, out_wdata=0x99999999.
REQ-029 Write RAW=0xDEADBEEF -> out_wen high only cycle E0..E1, out_wdata=0xDEADBEEF, busy stays 0.
REQ-030 BIN=1111 then BIN=2222 at E10 of first -> no pulse for 1111; pulse 27 cycles after second accept with 0x00002222.
REQ-031 BIN=5 then RAW=0x0000ABCD at E5 -> only one out_wen, value 0x0000ABCD, busy low after that edge.
REQ-032 BIN=87_654_321, assert rst at E15 -> out_wen never pulses, out_wdata=0, busy=0, rdata@STAT=0.
